// File: rtl/demux8b_stream_pkg.sv
// Shared constants for the demux8b_stream block: route-select encodings,
// default FIFO depth and the width of the optional transfer counters.
package demux8b_stream_pkg;

  localparam logic SEL_A         = 1'b0;
  localparam logic SEL_B         = 1'b1;
  localparam int   DEPTH_DEFAULT = 2;
  localparam int   STATS_W       = 16;

endpackage

// File: rtl/demux8b_stream_fifo.sv
// demux_fifo: per-output buffer with a registered head word. The head holds
// its last value while the buffer is empty, and is 0 after reset.
module demux_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_d   = dout_q;
    // A write landing in the slot about to become head bypasses the array.
    if (cnt_d != '0)
      dout_d = (do_push && rd_ptr_d == wr_ptr_q) ? din : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/demux8b_stream.sv
// Two-way stream demultiplexer: each input word is routed by Sel into an
// independent A or B FIFO. Define DEMUX8B_STREAM_STATS_EN for A_cnt/B_cnt.
module demux8b_stream
  import demux8b_stream_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       F,
  input  logic               F_valid,
  output logic               F_ready,
  input  logic               Sel,
  output logic [W-1:0]       A,
  output logic               A_valid,
  input  logic               A_ready,
  output logic [W-1:0]       B,
  output logic               B_valid,
  input  logic               B_ready
`ifdef DEMUX8B_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0] A_cnt,
  output logic [STATS_W-1:0] B_cnt
`endif
);

  logic a_full, a_empty, b_full, b_empty;
  logic push_a, push_b, pop_a, pop_b;

  // Ready comes only from registered counts, so a same-cycle pop cannot open it.
  assign F_ready = (Sel == SEL_A) ? !a_full : !b_full;
  assign push_a  = F_valid && F_ready && (Sel == SEL_A);
  assign push_b  = F_valid && F_ready && (Sel == SEL_B);
  assign A_valid = !a_empty;
  assign B_valid = !b_empty;
  assign pop_a   = A_valid && A_ready;
  assign pop_b   = B_valid && B_ready;

  demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(push_a), .din(F), .pop(pop_a),
    .full(a_full), .empty(a_empty), .dout(A)
  );

  demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(push_b), .din(F), .pop(pop_b),
    .full(b_full), .empty(b_empty), .dout(B)
  );

`ifdef DEMUX8B_STREAM_STATS_EN
  logic [STATS_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q + STATS_W'(pop_a);
    b_cnt_d = b_cnt_q + STATS_W'(pop_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_cnt = a_cnt_q;
  assign B_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_demux8b_stream.sv
// Directed bench for demux8b_stream: stimulus queues expected words, a
// negedge monitor pops and compares on every output handshake.
module tb_demux8b_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] F;
  logic       F_valid, F_ready, Sel;
  logic [7:0] A, B;
  logic       A_valid, A_ready, B_valid, B_ready;
`ifdef DEMUX8B_STREAM_STATS_EN
  logic [15:0] A_cnt, B_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  demux8b_stream #(.DEPTH(2), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .F(F), .F_valid(F_valid), .F_ready(F_ready),
    .Sel(Sel), .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready)
`ifdef DEMUX8B_STREAM_STATS_EN
    , .A_cnt(A_cnt), .B_cnt(B_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, return at the falling edge.
  task automatic cyc(input logic fv, input logic sel, input logic [7:0] f,
                     input logic ar, input logic br);
    @(posedge clk); #1;
    F_valid = fv; Sel = sel; F = f; A_ready = ar; B_ready = br;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (A_valid && A_ready) begin
        if (exp_a.size() == 0) chk("a_unexpected_word", 32'(A), 32'hDEAD);
        else chk("a_data", 32'(A), 32'(exp_a.pop_front()));
      end
      if (B_valid && B_ready) begin
        if (exp_b.size() == 0) chk("b_unexpected_word", 32'(B), 32'hDEAD);
        else chk("b_data", 32'(B), 32'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; F = '0; F_valid = 1'b0; Sel = 1'b0; A_ready = 1'b0; B_ready = 1'b0;
    #12;
    chk("rst_a_valid", 32'(A_valid), 0);
    chk("rst_b_valid", 32'(B_valid), 0);
    chk("rst_a_data",  32'(A), 0);
    chk("rst_b_data",  32'(B), 0);
    chk("rst_f_ready", 32'(F_ready), 1);
    #5 rst_n = 1'b1;

    // Alternate routing, one-cycle latency, push+pop on empty keeps valid low
    cyc(1, 0, 8'hAA, 1, 1); exp_a.push_back(8'hAA);
    chk("t1_ready", 32'(F_ready), 1);
    chk("t1_a_not_yet", 32'(A_valid), 0);
    cyc(1, 1, 8'h55, 1, 1); exp_b.push_back(8'h55);
    chk("t1_a_valid", 32'(A_valid), 1);
    chk("t1_b_not_yet", 32'(B_valid), 0);
    cyc(0, 0, 8'h00, 1, 1);
    chk("t1_b_valid", 32'(B_valid), 1);
    chk("t1_a_drained", 32'(A_valid), 0);
    cyc(0, 0, 8'h00, 1, 1);

    // Fill A, third push held
    cyc(1, 0, 8'hF0, 0, 1); exp_a.push_back(8'hF0);
    chk("fill_ready0", 32'(F_ready), 1);
    cyc(1, 0, 8'h0F, 0, 1); exp_a.push_back(8'h0F);
    chk("fill_ready1", 32'(F_ready), 1);
    cyc(1, 0, 8'h33, 0, 1);
    chk("full_hold", 32'(F_ready), 0);
    chk("full_head", 32'(A), 32'hF0);
    cyc(1, 0, 8'h33, 0, 1);
    chk("full_hold2", 32'(F_ready), 0);
    chk("full_head_stable", 32'(A), 32'hF0);
    chk("full_valid_stable", 32'(A_valid), 1);

    // A full, B still open
    cyc(1, 1, 8'h3C, 0, 1); exp_b.push_back(8'h3C);
    chk("b_while_a_full", 32'(F_ready), 1);

    // Pop on full A does not open ready the same cycle
    cyc(1, 0, 8'h33, 1, 1);
    chk("pop_full_no_ready", 32'(F_ready), 0);
    chk("b_arrived", 32'(B_valid), 1);
    chk("a_unchanged", 32'(A), 32'hF0);
    cyc(1, 0, 8'h33, 0, 1); exp_a.push_back(8'h33);
    chk("ready_after_pop", 32'(F_ready), 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("a_drained", 32'(A_valid), 0);
    chk("a_hold_last", 32'(A), 32'h33);
    chk("exp_a_empty1", exp_a.size(), 0);
    chk("exp_b_empty1", exp_b.size(), 0);

    // Streaming push+pop at count 1 keeps ready high
    cyc(1, 0, 8'h11, 1, 1); exp_a.push_back(8'h11);
    chk("stream_ready0", 32'(F_ready), 1);
    cyc(1, 0, 8'h22, 1, 1); exp_a.push_back(8'h22);
    chk("stream_ready1", 32'(F_ready), 1);
    cyc(1, 0, 8'h44, 1, 1); exp_a.push_back(8'h44);
    chk("stream_ready2", 32'(F_ready), 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("stream_done", 32'(A_valid), 0);

    // B stalled and full; A unaffected
    cyc(1, 1, 8'hB1, 1, 0); exp_b.push_back(8'hB1);
    cyc(1, 1, 8'hB2, 1, 0); exp_b.push_back(8'hB2);
    cyc(1, 1, 8'hB3, 1, 0);
    chk("b_full_hold", 32'(F_ready), 0);
    cyc(1, 0, 8'hA1, 1, 0); exp_a.push_back(8'hA1);
    chk("a_open_b_full", 32'(F_ready), 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("a1_out", 32'(A_valid), 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("exp_b_empty2", exp_b.size(), 0);

    // Reset with two words buffered in A
    cyc(1, 0, 8'hAB, 0, 1); exp_a.push_back(8'hAB);
    cyc(1, 0, 8'hCD, 0, 1); exp_a.push_back(8'hCD);
    cyc(0, 0, 8'h00, 0, 1);
    chk("pre_rst_valid", 32'(A_valid), 1);
    #2 rst_n = 1'b0; exp_a.delete();
    #1;
    chk("mid_rst_a_valid", 32'(A_valid), 0);
    chk("mid_rst_a_data", 32'(A), 0);
    chk("mid_rst_ready", 32'(F_ready), 1);
    @(negedge clk); #2 rst_n = 1'b1;
    cyc(1, 0, 8'h81, 1, 1); exp_a.push_back(8'h81);
    cyc(0, 0, 8'h00, 1, 1);
    chk("post_rst_valid", 32'(A_valid), 1);
    chk("post_rst_data", 32'(A), 32'h81);

    // Four more A and three B transfers (5 A / 3 B since reset)
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 8'(i), 1, 1); exp_a.push_back(8'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 1, 8'(8'h90 + i), 1, 1); exp_b.push_back(8'(8'h90 + i));
    end
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);
    chk("exp_a_empty_end", exp_a.size(), 0);
    chk("exp_b_empty_end", exp_b.size(), 0);
`ifdef DEMUX8B_STREAM_STATS_EN
    chk("a_cnt", 32'(A_cnt), 5);
    chk("b_cnt", 32'(B_cnt), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux8b_stream.md
DEMUX8B_STREAM -- requirements
Module: demux8b_stream

Interface
- REQ-001: Parameter DEPTH, default 2, sets per-output FIFO depth in entries; legal values 2, 4 or 8.
- REQ-002: Parameter W, default 8, sets data width in bits.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: F  input  W  input data word.
- REQ-006: F_valid  input  1  input word present.
- REQ-007: F_ready  output  1  block accepts the input word this cycle.
- REQ-008: Sel  input  1  route select, sampled with F: 0 selects output A, 1 selects output B.
- REQ-009: A  output  W  head word of the A FIFO.
- REQ-010: A_valid  output  1  A FIFO non-empty.
- REQ-011: A_ready  input  1  consumer takes A this cycle.
- REQ-012: B, B_valid, B_ready SHALL mirror REQ-009..REQ-011 for output B.

Function
- REQ-013: An input transfer SHALL occur on a clock edge where F_valid=1 and F_ready=1; F is pushed into the FIFO named by Sel.
- REQ-014: F_ready SHALL be 1 exactly when the FIFO named by the current Sel holds fewer than DEPTH entries; it is a function of registered counts and Sel only, with no path from A_ready or B_ready.
- REQ-015: A pop on a FIFO full in the same cycle SHALL NOT raise F_ready for that cycle.
- REQ-016: A word accepted at edge N SHALL appear on its output with valid=1 after edge N, i.e. in the following cycle, if that FIFO was empty.
- REQ-017: An output transfer SHALL occur on an edge where X_valid=1 and X_ready=1 (X in A, B); the next entry is presented in the following cycle.
- REQ-018: Each FIFO SHALL preserve arrival order; A and B SHALL be fully independent, with no head-of-line blocking between them.
- REQ-019: A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave its count unchanged and lose no data.
- REQ-020: A simultaneous push and pop on an empty FIFO SHALL leave valid low that cycle; the pushed word appears the next cycle.
- REQ-021: Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits.
- REQ-022: X and X_valid SHALL remain stable while X_valid=1 and X_ready=0.
- REQ-023: While a FIFO is empty, its data output SHALL hold its last value (0 after reset).

Reset
- REQ-024: On rst_n=0, all of the following SHALL be forced immediately, independent of clk: counts and pointers to 0, A_valid=0, B_valid=0, A=0, B=0.
- REQ-025: F_ready SHALL be 1 while in reset, because both FIFOs are empty; no transfer is recorded until rst_n is high at a clock edge.
- REQ-026: Reset asserted mid-operation SHALL discard all buffered words; the first post-reset push SHALL be the next output.

Configuration
- REQ-027: With DEMUX8B_STREAM_STATS_EN defined, the block SHALL add output ports A_cnt and B_cnt (each 16 bits). Each counts completed output transfers on its side, wraps 0xFFFF to 0x0000, and resets to 0.
- REQ-028: Without DEMUX8B_STREAM_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-029: The shared include SHALL define the select encodings SEL_A=0 and SEL_B=1, DEPTH_DEFAULT=2, and the stats counter width 16.
- REQ-030: The per-output buffer SHALL be one sub-module, demux_fifo (parameters W and DEPTH; push/full, pop/empty, data out), instantiated twice.

Verification
- REQ-031: Reset, then F=0xAA with Sel=0 and F=0x55 with Sel=1 on consecutive cycles, A_ready=B_ready=1 -> A=0xAA, then B=0x55, each exactly one cycle after acceptance.
- REQ-032: With DEPTH=2 and A_ready=0, push 0xF0, 0x0F, 0x33 to A -> the third push is held with F_ready=0; raising A_ready yields 0xF0, 0x0F, 0x33 in order.
- REQ-033: With A full and B_ready=1, switch Sel=1 and push 0x3C -> F_ready=1 and B=0x3C the next cycle, with A contents unchanged.
- REQ-034: With A full, pulse A_ready and drive F_valid with Sel=0 in the same cycle -> F_ready stays 0 that cycle and the push is accepted the next cycle.
- REQ-035: With two words buffered in A, assert rst_n=0 between edges -> A_valid=0 immediately; after release, push 0x81 -> A=0x81 is the next output.
- REQ-036: With DEMUX8B_STREAM_STATS_EN defined, perform 5 A transfers and 3 B transfers -> A_cnt=5, B_cnt=3.
